// File: rtl/pc_sequencer_pkg.sv
// Shared next-PC encoding and fetch FSM state type for the IF stage.
// The pcsource encoding is also used by the ID-stage decoder.
package pcsrc_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master) and imem (slave).
interface pc_sequencer_if #(parameter int AW = 32);

    logic          req;
    logic [AW-1:0] addr;
    logic          ready;
    logic [31:0]   rdata;

    modport master (output req, addr, input ready, rdata);
    modport slave  (input req, addr, output ready, rdata);

endinterface

// File: rtl/pc_sequencer_target_mux.sv
// Selects the redirect target named by the ID-stage pcsource code.
module pc_target_mux
    import pcsrc_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [1:0]    pcsource,
    input  logic [AW-1:0] bpc,
    input  logic [AW-1:0] rpc,
    input  logic [AW-1:0] jpc,
    output logic [AW-1:0] target
);

    always_comb begin
        target = '0;
        case (pcsource)
            PCSRC_BR: target = bpc;
            PCSRC_JR: target = rpc;
            PCSRC_J:  target = jpc;
            default:  target = '0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and imem handshake with delayed-branch redirects; absorbs
// memory wait states and ID stalls without dropping or duplicating an instruction.
module pc_sequencer
    import pcsrc_pkg::*;
#(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           stall,
    input  logic           id_valid,
    input  logic [1:0]     pcsource,
    input  logic [AW-1:0]  bpc,
    input  logic [AW-1:0]  rpc,
    input  logic [AW-1:0]  jpc,
    pc_sequencer_if.master imem,
    output logic           if_valid,
    output logic [31:0]    if_inst,
    output logic [AW-1:0]  if_pc4,
    output logic           pend_redirect
);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_seq;
    logic [AW-1:0] target;
    logic          pend_v;
    logic [AW-1:0] pend_tgt;
    logic [31:0]   hold_word;
    logic          req;
    logic          deliver;
    logic          capture;
    logic          redir;

    pc_target_mux #(.AW(AW)) target_mux (
        .pcsource (pcsource),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .target   (target)
    );

    assign pc_seq        = pc + AW'(4);
    assign redir         = id_valid & ~stall & (pcsource != PCSRC_SEQ);
    assign imem.req      = req;
    assign imem.addr     = pc;
    assign pend_redirect = pend_v;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN:  if (~stall & ~imem.ready) state_next = WAIT;
            WAIT: if (imem.ready) state_next = stall ? HOLD : RUN;
            HOLD: if (~stall) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    // req depends only on state and stall so imem.ready never loops back into it.
    always_comb begin
        req     = 1'b0;
        deliver = 1'b0;
        capture = 1'b0;
        case (state)
            RUN: begin
                req     = ~stall;
                deliver = ~stall & imem.ready;
            end
            WAIT: begin
                req     = 1'b1;
                deliver = imem.ready & ~stall;
                capture = imem.ready & stall;
            end
            HOLD: deliver = ~stall;
            default: ;
        endcase
        if_valid = deliver;
        if_inst  = '0;
        if_pc4   = '0;
        if (deliver) begin
            if_inst = (state == HOLD) ? hold_word : imem.rdata;
            if_pc4  = pc_seq;
        end
    end

    // A redirect that misses the delay-slot deliver waits in pend until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            pend_v    <= 1'b0;
            pend_tgt  <= '0;
            hold_word <= '0;
        end else begin
            if (deliver) begin
                pc     <= pend_v ? pend_tgt : (redir ? target : pc_seq);
                pend_v <= 1'b0;
            end else if (redir & ~pend_v) begin
                pend_v   <= 1'b1;
                pend_tgt <= target;
            end
            if (capture) begin
                hold_word <= imem.rdata;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an instruction-stream model predicts every
// delivered word and pc+4, with directed corner cases followed by random traffic.
module tb_pc_sequencer;
    import pcsrc_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        id_valid;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        pend_redirect;
    logic [31:0] junk;

    int tests = 0;
    int fails = 0;
    int deliveries = 0;

    logic [31:0] exp_q[$];
    logic        model_out;
    logic [31:0] model_tgt;
    logic        prev_stuck;
    logic [31:0] prev_addr;

    pc_sequencer_if imem ();

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .id_valid      (id_valid),
        .pcsource      (pcsource),
        .bpc           (bpc),
        .rpc           (rpc),
        .jpc           (jpc),
        .imem          (imem),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc4        (if_pc4),
        .pend_redirect (pend_redirect)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory returns a deterministic word per address; garbage when not ready.
    assign imem.rdata = imem.ready ? mem_word(imem.addr) : junk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
                     name, $time, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic iv,
                                  input logic [1:0] src, input logic rdy);
        @(posedge clock);
        #1;
        stall      = s;
        id_valid   = iv;
        pcsource   = src;
        imem.ready = rdy;
        junk       = $urandom;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        model_out = 1'b0;
        model_tgt = '0;
    endtask

    // Program-order model: a redirect steers the instruction that follows the
    // next delivered one; a second redirect before that is dropped.
    always @(negedge clock) begin
        logic [31:0] e;
        if (reset) begin
            prev_stuck = 1'b0;
        end else begin
            check_output("pend_redirect", 32'(pend_redirect), 32'(model_out));
            if (prev_stuck) check_output("addr_stable", imem.addr, prev_addr);
            if (id_valid && !stall && pcsource != PCSRC_SEQ && !model_out) begin
                model_out = 1'b1;
                model_tgt = (pcsource == PCSRC_BR) ? bpc :
                            (pcsource == PCSRC_JR) ? rpc : jpc;
            end
            if (if_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_output("if_inst", if_inst, mem_word(e));
                    check_output("if_pc4", if_pc4, e + 32'd4);
                    exp_q.push_back(model_out ? model_tgt : e + 32'd4);
                    model_out = 1'b0;
                    deliveries++;
                end
            end
            prev_stuck = imem.req && !imem.ready;
            prev_addr  = imem.addr;
        end
    end

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        id_valid   = 1'b0;
        pcsource   = PCSRC_SEQ;
        bpc        = '0;
        rpc        = '0;
        jpc        = '0;
        junk       = '0;
        imem.ready = 1'b1;
        prev_stuck = 1'b0;
        prev_addr  = '0;
        model_reset();

        #1;
        check_output("reset_req", 32'(imem.req), 32'd0);
        check_output("reset_if_valid", 32'(if_valid), 32'd0);
        check_output("reset_addr", imem.addr, RESET_PC);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check_output("boot_req", 32'(imem.req), 32'd0);
        @(negedge clock);
        check_output("first_req", 32'(imem.req), 32'd1);
        check_output("first_addr", imem.addr, RESET_PC);

        // Zero-wait sequential fetch
        repeat (8) apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b1);

        // Taken branch delivered together with its delay slot
        bpc = 32'h0000_0100;
        apply_stimulus(1'b0, 1'b1, PCSRC_BR, 1'b1);
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b1);
        @(negedge clock);
        check_output("branch_addr", imem.addr, 32'h0000_0100);

        // jr arriving while the delay slot waits three cycles on memory
        rpc = 32'h0000_0040;
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b0);
        apply_stimulus(1'b0, 1'b1, PCSRC_JR, 1'b0);
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b0);
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b1);
        @(negedge clock);
        check_output("jr_pending", 32'(pend_redirect), 32'd1);
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b1);
        @(negedge clock);
        check_output("jr_addr", imem.addr, 32'h0000_0040);
        check_output("jr_pend_clear", 32'(pend_redirect), 32'd0);

        // Stall during a wait: word is buffered, then delivered once on release
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b0);
        apply_stimulus(1'b1, 1'b0, PCSRC_SEQ, 1'b0);
        apply_stimulus(1'b1, 1'b0, PCSRC_SEQ, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, PCSRC_SEQ, 1'($urandom_range(0, 1)));
            @(negedge clock);
            check_output("hold_req", 32'(imem.req), 32'd0);
            check_output("hold_if_valid", 32'(if_valid), 32'd0);
        end
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b0);
        @(negedge clock);
        check_output("hold_release", 32'(if_valid), 32'd1);

        // Sequential wrap at the top of the address space
        jpc = 32'hFFFF_FFFC;
        apply_stimulus(1'b0, 1'b1, PCSRC_J, 1'b1);
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b1);
        @(negedge clock);
        check_output("wrap_pc4", if_pc4, 32'h0000_0000);
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b1);
        @(negedge clock);
        check_output("wrap_addr", imem.addr, 32'h0000_0000);

        // Asynchronous reset in WAIT with a captured redirect
        bpc = 32'h0000_0200;
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b0);
        apply_stimulus(1'b0, 1'b1, PCSRC_BR, 1'b0);
        apply_stimulus(1'b0, 1'b0, PCSRC_SEQ, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_output("areset_req", 32'(imem.req), 32'd0);
        check_output("areset_if_valid", 32'(if_valid), 32'd0);
        check_output("areset_pend", 32'(pend_redirect), 32'd0);
        check_output("areset_addr", imem.addr, RESET_PC);
        check_output("areset_inst", if_inst, 32'd0);
        check_output("areset_pc4", if_pc4, 32'd0);
        model_reset();
        stall      = 1'b0;
        id_valid   = 1'b0;
        pcsource   = PCSRC_SEQ;
        imem.ready = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check_output("reboot_req", 32'(imem.req), 32'd0);
        @(negedge clock);
        check_output("reboot_req_on", 32'(imem.req), 32'd1);
        check_output("reboot_addr", imem.addr, RESET_PC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bpc = $urandom & 32'hFFFF_FFFC;
            rpc = $urandom & 32'hFFFF_FFFC;
            jpc = $urandom & 32'hFFFF_FFFC;
            apply_stimulus(($urandom % 4) == 0, 1'($urandom % 2),
                           (($urandom % 6) == 0) ? 2'($urandom_range(1, 3)) : PCSRC_SEQ,
                           ($urandom % 3) != 0);
        end
        @(negedge clock);
        check_output("progress", 32'(deliveries > 400), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
